// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer slice.
// Holds the mode encoding and the select-field width rule.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Select/channel-ID width: enough bits to index every channel, never zero.
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping around, and reports the grant both one-hot and as an index.
module rr_arbiter #(
  parameter int NCH  = 9,
  parameter int SELW = 4
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx
);

  always_comb begin
    int              cand;
    logic [SELW-1:0] cand_idx;
    logic            found;
    // NOTE: every output and local gets a default before any conditional
    // assignment, so no path through the block leaves a value unassigned
    // and no latch is inferred.
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Search order starts one past the last winner, so the previous grantee
    // is considered last.
    for (int off = 1; off <= NCH; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = SELW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with fixed or round-robin channel selection
// feeding a single registered output slot with valid/ready handshakes.
module stream_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 9,
  localparam int SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [NCH-1:0]   fixed_grant;
  logic [NCH-1:0]   rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             slot_free;
  logic             in_xfer;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Shifting a single one by sel yields zero for out-of-range selects.
  assign fixed_grant = NCH'(1) << sel;

  assign grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (rst_n && slot_free) ? grant : '0;
  assign in_xfer   = |(in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      grant_data = grant_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    // A held word only moves when the slot frees; data/ID persist when idle.
    if (slot_free) begin
      out_valid_d = in_xfer;
      if (in_xfer) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        if (mode == MODE_RR) ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data and channel-ID registers are reset too, not only the
      // valid flag, so the output bus reads zero after reset.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples its next-state value from the same pre-edge snapshot.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: stimulus pushes expected words into a
// scoreboard queue, a monitor pops them on each output transfer.
module tb_stream_mux;

  localparam int WIDTH = 16;
  localparam int NCH   = 9;
  localparam int SELW  = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Channel k carries value k, except channel 8 which carries 9.
  function automatic int exp_data(input int k);
    return (k == 8) ? 9 : k;
  endfunction

  function automatic logic [NCH-1:0] oh(input int k);
    logic [NCH-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic push(input int c);
    exp_t e;
    e.data = WIDTH'(exp_data(c));
    e.ch   = SELW'(c);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented-and-accepted word must match the queue head.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got data %0h ch %0h, expected none", out_data, out_ch);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_out_data", 64'(out_data), 64'(mon_e.data));
        check("mon_out_ch", 64'(out_ch), 64'(mon_e.ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_legal;
    rst_n     = 1'b0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(exp_data(k));

    // Reset state, with all channels requesting.
    next_cycle();
    in_valid = '1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    next_cycle();
    rst_n = 1'b1;

    // Fixed mode, sel swept 0..15; 9..15 are out of range.
    prev_legal = 1'b0;
    for (int s = 0; s < 16; s++) begin
      sel = SELW'(s);
      if (s < NCH) push(s);
      @(negedge clk);
      check("fix_in_ready", 64'(in_ready), (s < NCH) ? 64'(oh(s)) : 64'(0));
      check("fix_out_valid", 64'(out_valid), 64'(prev_legal));
      prev_legal = (s < NCH);
      next_cycle();
    end
    @(negedge clk);
    check("fix_tail_valid", 64'(out_valid), 64'(0));
    next_cycle();

    // Round robin, all valid: 0,1,...,8,0 back to back.
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(i % NCH);
      @(negedge clk);
      check("rr_in_ready", 64'(in_ready), 64'(oh(i % NCH)));
      if (i > 0) check("rr_no_bubble", 64'(out_valid), 64'(1));
      next_cycle();
    end

    // Round robin, only channels 2 and 7 valid.
    in_valid = oh(2) | oh(7);
    for (int i = 0; i < 4; i++) begin
      push((i % 2 == 1) ? 7 : 2);
      @(negedge clk);
      check("rr27_in_ready", 64'(in_ready), 64'(oh((i % 2 == 1) ? 7 : 2)));
      next_cycle();
    end

    // Backpressure holding data 5 for three cycles.
    in_valid = '1;
    mode     = 1'b0;
    sel      = 4'd5;
    push(5);
    @(negedge clk);
    check("bp_in_ready_pre", 64'(in_ready), 64'(oh(5)));
    next_cycle();
    out_ready = 1'b0;
    sel       = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_data", 64'(out_data), 64'(5));
      check("bp_hold_ch", 64'(out_ch), 64'(5));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      next_cycle();
    end
    out_ready = 1'b1;
    push(6);
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'(oh(6)));
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    check("bp_no_bubble", 64'(out_valid), 64'(1));
    check("bp_next_ch", 64'(out_ch), 64'(6));
    next_cycle();
    @(negedge clk);
    check("idle_valid_drop", 64'(out_valid), 64'(0));
    check("idle_data_hold", 64'(out_data), 64'(6));
    check("idle_ch_hold", 64'(out_ch), 64'(6));
    next_cycle();

    // Mode toggle RR->fixed (sel=4) while stalled; ptr is 7 so RR grants 8.
    in_valid = '1;
    mode     = 1'b1;
    push(8);
    @(negedge clk);
    check("tog_in_ready_rr", 64'(in_ready), 64'(oh(8)));
    next_cycle();
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 4'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("tog_hold_data", 64'(out_data), 64'(9));
      check("tog_hold_ch", 64'(out_ch), 64'(8));
      check("tog_in_ready", 64'(in_ready), 64'(0));
      next_cycle();
    end
    out_ready = 1'b1;
    push(4);
    @(negedge clk);
    check("tog_release_ready", 64'(in_ready), 64'(oh(4)));
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    check("tog_next_ch", 64'(out_ch), 64'(4));
    next_cycle();

    // Reset while a word is stalled; ptr moved to 1 so RR restart proves the reset.
    in_valid = '1;
    mode     = 1'b1;
    push(0);
    next_cycle();
    push(1);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("rstx_hold_ch", 64'(out_ch), 64'(1));
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstx_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    next_cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(0);
    @(negedge clk);
    check("rstx_out_valid", 64'(out_valid), 64'(0));
    check("rstx_out_data", 64'(out_data), 64'(0));
    check("rstx_out_ch", 64'(out_ch), 64'(0));
    check("rstx_first_grant", 64'(in_ready), 64'(oh(0)));
    next_cycle();
    push(1);
    @(negedge clk);
    check("rstx_second_grant", 64'(in_ready), 64'(oh(1)));
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 16: data width per channel, legal range 1 to 64.
REQ-002 Parameter NCH, default 9: number of input channels, legal range 2 to 16.
REQ-003 Localparam SELW = max(1, clog2(NCH)): width of the select and channel-ID fields.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-006 Port in_data, input, NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, NCH: per-channel data-valid.
REQ-008 Port in_ready, output, NCH: per-channel accept; a transfer on channel k = in_valid[k] & in_ready[k].
REQ-009 Port mode, input, 1: 0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR).
REQ-010 Port sel, input, SELW: channel index, used only in MODE_FIXED.
REQ-011 Port out_data, output, WIDTH: registered output data.
REQ-012 Port out_valid, output, 1: out_data/out_ch hold a valid word.
REQ-013 Port out_ready, input, 1: downstream accept; an output transfer = out_valid & out_ready.
REQ-014 Port out_ch, output, SELW: source channel index of out_data.

Function
REQ-015 The output stage SHALL be one register slot; the slot is "free" when !out_valid | out_ready.
REQ-016 At most one bit of in_ready SHALL be high per cycle; in_ready[k] = grant[k] & free.
REQ-017 MODE_FIXED: grant = onehot(sel) when sel < NCH; when sel >= NCH, grant = 0 and no input transfer occurs.
REQ-018 MODE_RR: grant SHALL go to the first channel with in_valid set, searching from (ptr+1) mod NCH upward with wrap-around; grant = 0 if no valid.
REQ-019 The RR pointer ptr SHALL update to the granted index only on an input transfer; in MODE_FIXED ptr is unchanged.
REQ-020 On an input transfer: out_data <= granted channel data, out_ch <= granted index, out_valid <= 1; latency input to output = 1 cycle.
REQ-021 If the slot is free and no input transfer occurs, out_valid SHALL drop to 0 next cycle; out_data/out_ch hold their values.
REQ-022 While out_valid & !out_ready, out_data/out_ch/out_valid SHALL remain stable regardless of mode, sel or input changes.
REQ-023 Simultaneous output transfer and input transfer in one cycle SHALL sustain throughput of 1 word/cycle with no bubble.
REQ-024 mode and sel are sampled combinationally each cycle; a change affects only the grant in that cycle, never held output data.
REQ-025 Grant SHALL not depend on out_ready when the slot is free via !out_valid (no combinational path out_ready->in_ready is forbidden, but none from in_valid->out_valid).

Reset
REQ-026 When rst_n = 0 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= NCH-1 (first RR grant goes to channel 0).
REQ-027 During the reset cycle in_ready SHALL be all-zero; reset mid-transfer discards the held word.

Structure
REQ-028 Constants MODE_FIXED and MODE_RR SHALL live in shared package mux_pkg.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req[NCH], ptr; output onehot grant and index).
REQ-030 Implementation SHALL fit 120-400 lines RTL, fully parametrised, no per-NCH hand-written cases.

Verification
REQ-031 Fixed mode, NCH=9, WIDTH=16, in_data[k]=k (9 for k=8), all valid, out_ready=1, sel stepped 0..15 -> out_data 0..7,9 with out_ch=sel one cycle later; sel 9..15 -> out_valid=0, in_ready=0.
REQ-032 RR mode, all 9 channels valid, out_ready=1 -> out_ch sequence 0,1,...,8,0 with one word per cycle.
REQ-033 RR mode, only channels 2 and 7 valid -> out_ch alternates 2,7,2,7; channels never granted when invalid.
REQ-034 Backpressure: out_ready=0 for 3 cycles after out_data=5 -> out_data=5 stable, in_ready=0 throughout; on out_ready=1 next word follows with no bubble.
REQ-035 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0; first RR grant afterwards is channel 0.
REQ-036 Toggle mode 1->0 with sel=4 while output stalled -> held word unchanged; after release next word comes from channel 4.
